// File: rtl/interface_ultrassom_direcao_pkg.sv
// sga_interface_pkg: shared FSM encodings and default timing constants for the ultrasonic steering front-end.
package sga_interface_pkg;
    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        DISPARA = 4'd1,
        MEDE    = 4'd2,
        DECIDE  = 4'd3,
        PRONTO  = 4'd4
    } estado_t;
    localparam int CLK_HZ                 = 50_000_000;
    localparam int TRIGGER_CYCLES_DEF     = 500;
    localparam int CYCLES_PER_CM_DEF      = 2941;
    localparam int TIMEOUT_CYCLES_DEF     = 1_500_000;
    localparam int LIMIAR_CM_DEF          = 10;
    localparam int DIST_W                 = 9;
endpackage

// File: rtl/interface_ultrassom_direcao_medidor_echo.sv
// medidor_echo: measures one synchronised echo pulse width in centimetres, saturating at the output width.
module medidor_echo
    import sga_interface_pkg::*;
#(
    parameter int CYCLES_PER_CM = CYCLES_PER_CM_DEF,
    parameter int DIST_W_P      = DIST_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_echo,
    input  logic                i_en,
    input  logic                i_clr,
    output logic [DIST_W_P-1:0] o_dist,
    output logic                o_done
);
    localparam int CYC_W = $clog2(CYCLES_PER_CM + 1);
    logic                r_prev;
    logic                r_ativo;
    logic                r_done;
    logic [CYC_W-1:0]    r_cyc;
    logic [DIST_W_P-1:0] r_dist;
    logic                w_rise;
    logic                w_conta;
    logic                w_wrap;
    // an echo already high on entry has r_prev=1, so it needs a fresh rising edge
    assign w_rise  = i_echo & ~r_prev;
    assign w_conta = i_en & ~r_done & (r_ativo | w_rise);
    assign w_wrap  = r_cyc == CYC_W'(CYCLES_PER_CM - 1);
    assign o_dist  = r_dist;
    assign o_done  = r_done;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev  <= 1'b0;
            r_ativo <= 1'b0;
            r_done  <= 1'b0;
            r_cyc   <= '0;
            r_dist  <= '0;
        end else begin
            r_prev <= i_echo;
            if (i_clr) begin
                r_ativo <= 1'b0;
                r_done  <= 1'b0;
                r_cyc   <= '0;
                r_dist  <= '0;
            end else if (w_conta) begin
                if (!i_echo) begin
                    r_done  <= 1'b1;
                    r_ativo <= 1'b0;
                end else begin
                    r_ativo <= 1'b1;
                    r_cyc   <= w_wrap ? '0 : r_cyc + 1'b1;
                    if (w_wrap && !(&r_dist))
                        r_dist <= r_dist + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/interface_ultrassom_direcao.sv
// interface_ultrassom_direcao: fires both HC-SR04 sensors, measures both echoes and returns a held left/right turn command.
module interface_ultrassom_direcao
    import sga_interface_pkg::*;
#(
    parameter int TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
    parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int LIMIAR_CM      = LIMIAR_CM_DEF,
    parameter int DIST_W_P       = DIST_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                medir,
    input  logic                echo_esq,
    input  logic                echo_dir,
    output logic                trigger_esq,
    output logic                trigger_dir,
    output logic [DIST_W_P-1:0] distancia_esq,
    output logic [DIST_W_P-1:0] distancia_dir,
    output logic                dir,
    output logic                esq,
    output logic                pronto,
    output logic                timeout,
    output logic [3:0]          db_estado
);
    localparam int MAXC  = TIMEOUT_CYCLES > TRIGGER_CYCLES ? TIMEOUT_CYCLES : TRIGGER_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [DIST_W_P-1:0] DIST_MAX = '1;
    estado_t             r_estado, w_prox;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_sync_esq, r_sync_dir;
    logic                r_trigger, r_pronto, r_dir, r_esq, r_timeout;
    logic [DIST_W_P-1:0] r_dist_esq, r_dist_dir;
    logic [DIST_W_P-1:0] w_cm_esq, w_cm_dir, w_dist_esq, w_dist_dir;
    logic                w_done_esq, w_done_dir, w_near_esq, w_near_dir;
    logic                w_clr, w_en, w_fim_disp, w_fim_tmo;
    assign w_clr      = r_estado == INICIAL && medir;
    assign w_en       = r_estado == MEDE;
    assign w_fim_disp = r_cnt == CNT_W'(TRIGGER_CYCLES - 1);
    assign w_fim_tmo  = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    medidor_echo #(.CYCLES_PER_CM(CYCLES_PER_CM), .DIST_W_P(DIST_W_P)) u_esq (
        .clock(clock), .reset(reset), .i_echo(r_sync_esq[1]), .i_en(w_en), .i_clr(w_clr),
        .o_dist(w_cm_esq), .o_done(w_done_esq)
    );
    medidor_echo #(.CYCLES_PER_CM(CYCLES_PER_CM), .DIST_W_P(DIST_W_P)) u_dir (
        .clock(clock), .reset(reset), .i_echo(r_sync_dir[1]), .i_en(w_en), .i_clr(w_clr),
        .o_dist(w_cm_dir), .o_done(w_done_dir)
    );
    // an unfinished sensor reads as far away
    assign w_dist_esq = w_done_esq ? w_cm_esq : DIST_MAX;
    assign w_dist_dir = w_done_dir ? w_cm_dir : DIST_MAX;
    assign w_near_esq = w_dist_esq <= DIST_W_P'(LIMIAR_CM);
    assign w_near_dir = w_dist_dir <= DIST_W_P'(LIMIAR_CM);
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL: w_prox = medir ? DISPARA : INICIAL;
            DISPARA: w_prox = w_fim_disp ? MEDE : DISPARA;
            MEDE:    w_prox = ((w_done_esq & w_done_dir) | w_fim_tmo) ? DECIDE : MEDE;
            DECIDE:  w_prox = PRONTO;
            default: w_prox = INICIAL;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= INICIAL;
            r_cnt      <= '0;
            r_sync_esq <= '0;
            r_sync_dir <= '0;
            r_trigger  <= 1'b0;
            r_pronto   <= 1'b0;
            r_dir      <= 1'b0;
            r_esq      <= 1'b0;
            r_timeout  <= 1'b0;
            r_dist_esq <= '0;
            r_dist_dir <= '0;
        end else begin
            r_estado   <= w_prox;
            r_cnt      <= (w_prox != r_estado || r_estado == INICIAL) ? '0 : r_cnt + 1'b1;
            r_sync_esq <= {r_sync_esq[0], echo_esq};
            r_sync_dir <= {r_sync_dir[0], echo_dir};
            r_trigger  <= w_prox == DISPARA;
            r_pronto   <= w_prox == PRONTO;
            if (r_estado == DECIDE) begin
                r_dist_esq <= w_dist_esq;
                r_dist_dir <= w_dist_dir;
                r_dir      <= w_near_dir & ~w_near_esq;
                r_esq      <= w_near_esq & ~w_near_dir;
                r_timeout  <= ~(w_done_esq & w_done_dir);
            end
        end
    end
    assign trigger_esq   = r_trigger;
    assign trigger_dir   = r_trigger;
    assign pronto        = r_pronto;
    assign dir           = r_dir;
    assign esq           = r_esq;
    assign timeout       = r_timeout;
    assign distancia_esq = r_dist_esq;
    assign distancia_dir = r_dist_dir;
    assign db_estado     = r_estado;
endmodule

// File: tb/tb_interface_ultrassom_direcao.sv
// tb_interface_ultrassom_direcao: directed scoreboard bench for the steering front-end, with a 6-bit-distance twin for saturation.
module tb_interface_ultrassom_direcao;
    localparam int T = 5, CPC = 10, TO = 2000, LIM = 10;
    typedef struct {
        logic [8:0] de, dd;
        logic       dr, es, tm;
    } exp_t;
    logic       clock = 1'b0, reset = 1'b0, medir = 1'b0, echo_esq = 1'b0, echo_dir = 1'b0;
    logic       trig_ea, trig_da, dir_a, esq_a, pr_a, tm_a;
    logic [8:0] de_a, dd_a;
    logic [3:0] st_a;
    logic       trig_eb, trig_db, dir_b, esq_b, pr_b, tm_b;
    logic [5:0] de_b, dd_b;
    logic [3:0] st_b;
    exp_t       q_a[$], q_b[$];
    int         tests = 0, fails = 0;

    interface_ultrassom_direcao #(.TRIGGER_CYCLES(T), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO),
                                  .LIMIAR_CM(LIM), .DIST_W_P(9)) u_dut (
        .clock(clock), .reset(reset), .medir(medir), .echo_esq(echo_esq), .echo_dir(echo_dir),
        .trigger_esq(trig_ea), .trigger_dir(trig_da), .distancia_esq(de_a), .distancia_dir(dd_a),
        .dir(dir_a), .esq(esq_a), .pronto(pr_a), .timeout(tm_a), .db_estado(st_a)
    );
    interface_ultrassom_direcao #(.TRIGGER_CYCLES(T), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO),
                                  .LIMIAR_CM(LIM), .DIST_W_P(6)) u_sat (
        .clock(clock), .reset(reset), .medir(medir), .echo_esq(echo_esq), .echo_dir(echo_dir),
        .trigger_esq(trig_eb), .trigger_dir(trig_db), .distancia_esq(de_b), .distancia_dir(dd_b),
        .dir(dir_b), .esq(esq_b), .pronto(pr_b), .timeout(tm_b), .db_estado(st_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] clip6(input int v);
        return v > 63 ? 9'd63 : 9'(v);
    endfunction

    task automatic run(input int le, input int ld, input int ee, input int ed,
                       input logic edr, input logic ees, input logic etm,
                       input bit pre, input bit rep);
        exp_t x;
        int   n, extra, i;
        x.de = 9'(ee); x.dd = 9'(ed); x.dr = edr; x.es = ees; x.tm = etm;
        q_a.push_back(x);
        x.de = clip6(ee); x.dd = clip6(ed);
        q_b.push_back(x);
        @(negedge clock);
        medir = 1'b1;
        echo_esq = pre;
        @(negedge clock);
        medir = 1'b0;
        chk("trigger_dir_high", trig_da, 1);
        n = 0;
        while (trig_ea && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk("trigger_width", n, T);
        for (i = 0; i < 3000 && !pr_a; i++) begin
            echo_esq = pre ? (i < 20 || (i >= 30 && i < 30 + le)) : (i < le);
            echo_dir = i < ld;
            medir    = rep && (i == 10 || i == 11);
            @(negedge clock);
        end
        echo_esq = 1'b0;
        echo_dir = 1'b0;
        medir    = 1'b0;
        chk("pronto_seen", pr_a, 1);
        chk("pronto_twin", pr_b, 1);
        if (etm) chk("timeout_latency", (i >= 1995 && i <= 2010), 1);
        x = q_a.pop_front();
        chk("dist_esq", de_a, x.de);
        chk("dist_dir", dd_a, x.dd);
        chk("dir", dir_a, x.dr);
        chk("esq", esq_a, x.es);
        chk("timeout", tm_a, x.tm);
        x = q_b.pop_front();
        chk("sat_dist_esq", de_b, x.de);
        chk("sat_dist_dir", dd_b, x.dd);
        chk("sat_timeout", tm_b, x.tm);
        extra = 0;
        repeat (30) begin
            @(negedge clock);
            if (pr_a) extra++;
        end
        chk("single_pronto", extra, 0);
        chk("state_idle", st_a, 0);
        chk("hold_esq", esq_a, ees);
        chk("hold_dir", dir_a, edr);
    endtask

    initial begin
        int np;
        repeat (3) @(negedge clock);
        chk("rst_state", st_a, 0);
        chk("rst_trigger", trig_ea, 0);
        chk("rst_pronto", pr_a, 0);
        chk("rst_dist", de_a, 0);
        chk("rst_dir_esq", {dir_a, esq_a, tm_a}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        run(55, 300, 5, 30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(80, 80, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(300, 50, 30, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(120, 0, 12, 511, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(100, 300, 10, 30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(109, 200, 10, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(1995, 1995, 199, 199, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(1000, 1000, 100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(55, 300, 5, 30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run(70, 300, 7, 30, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // reset in the middle of a trigger pulse
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        chk("trigger_before_reset", trig_ea, 1);
        #2 reset = 1'b0;
        #1;
        chk("reset_drops_trigger_esq", trig_ea, 0);
        chk("reset_drops_trigger_dir", trig_da, 0);
        chk("reset_clears_esq", esq_a, 0);
        @(negedge clock);
        reset = 1'b1;
        // reset in the middle of a measurement
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        repeat (10) @(negedge clock);
        echo_dir = 1'b1;
        repeat (20) @(negedge clock);
        chk("mede_before_reset", st_a, 2);
        #2 reset = 1'b0;
        #1;
        chk("reset_state_async", st_a, 0);
        chk("reset_trigger", trig_ea, 0);
        chk("reset_outputs", {de_a, dd_a, dir_a, esq_a, tm_a, pr_a}, 0);
        @(negedge clock);
        echo_dir = 1'b0;
        reset = 1'b1;
        np = 0;
        repeat (100) begin
            @(negedge clock);
            if (pr_a) np++;
        end
        chk("no_pronto_after_reset", np, 0);
        chk("idle_after_reset", st_a, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/interface_ultrassom_direcao.md
Name: interface_ultrassom_direcao

Overview:
Upstream steering front-end for the Snake Game Arcade top level. On each `medir` request from the game control unit it fires the left and right HC-SR04 sensors together and measures both echo pulse widths in centimetres. It then classifies which hand is near and returns a one-cycle `pronto` with a held `{dir, esq}` turn command, which the control unit consumes as its interface direction. It replaces the ad-hoc trigger/echo logic inside the datapath with one self-contained, timeout-protected block.

Parameters:
TRIGGER_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
CYCLES_PER_CM, 2941, clocks of echo-high per centimetre (58.82 us/cm at 50 MHz)
TIMEOUT_CYCLES, 1500000, max clocks from trigger end to both echoes finished (30 ms)
LIMIAR_CM, 10, hand-near threshold; distance <= LIMIAR_CM counts as near
DIST_W, 9, width of the distance outputs

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
medir  in  1  start-measurement request; level or pulse, sampled only in INICIAL
echo_esq  in  1  left sensor echo, asynchronous
echo_dir  in  1  right sensor echo, asynchronous
trigger_esq  out  1  left sensor trigger
trigger_dir  out  1  right sensor trigger
distancia_esq  out  DIST_W  last left distance, cm
distancia_dir  out  DIST_W  last right distance, cm
dir  out  1  turn-right command, held until the next pronto
esq  out  1  turn-left command, held until the next pronto
pronto  out  1  one-cycle pulse: new dir/esq/distances valid
timeout  out  1  set with pronto if either echo did not finish; held until the next pronto
db_estado  out  4  FSM state code for hex display

Behaviour:
- Reset (asynchronous on reset=0): FSM=INICIAL; all outputs 0; distances 0; all counters 0.
- echo_esq and echo_dir pass through 2-flop synchronisers; all echo logic uses the synchronised copies.
- FSM states and codes:
  - INICIAL (0): idle; medir=1 -> DISPARA.
  - DISPARA (1): trigger_esq=trigger_dir=1 for exactly TRIGGER_CYCLES clocks, then -> MEDE. Both triggers are clocked outputs with no glitches.
  - MEDE (2): the timeout counter runs. Each sensor measures independently. The state exits when both sensors are done or the counter reaches TIMEOUT_CYCLES-1.
  - DECIDE (3): one cycle; register the distances, dir, esq and timeout.
  - PRONTO (4): pronto=1 for one cycle -> INICIAL.
- Per-sensor measurement in MEDE:
  - Waits for a rising edge of the synchronised echo, then counts.
  - A cycle counter wraps at CYCLES_PER_CM-1. Each wrap increments the cm counter, which saturates at 2^DIST_W-1.
  - A falling edge marks the sensor done.
  - Echo already high on entry to MEDE is ignored until it falls and rises again.
  - Pulses after done are ignored.
- Timeout: any sensor not done at timeout reports 2^DIST_W-1 (far) and sets timeout=1.
- Decision, computed in DECIDE:
  - near_x = distancia_x <= LIMIAR_CM.
  - dir = near_dir & ~near_esq; esq = near_esq & ~near_dir.
  - Both near or neither near -> dir=esq=0. dir=esq=1 never occurs.
- Latency: pronto appears at TRIGGER_CYCLES + t_meas + 2 clocks after medir is accepted (+2 for synchroniser delay on echo edges).
- medir asserted outside INICIAL is ignored; there is no queueing.
- If reset is asserted mid-operation, triggers drop immediately and no pronto is produced.

Decomposition:
- Shared package `sga_interface_pkg`:
  - state encodings (INICIAL..PRONTO);
  - default constants: 50 MHz clock, 10 us trigger, 58.82 us/cm, 30 ms timeout;
  - DIST_W.
- Sub-module `medidor_echo`, instantiated twice (left and right):
  - inputs: synchronised echo, enable (MEDE), clear (on entry to DISPARA);
  - outputs: distance, done.
- The top file holds the synchronisers, FSM, trigger counter, timeout counter and decision logic.

Test Plan:
All scenarios run with TRIGGER_CYCLES=5, CYCLES_PER_CM=10, TIMEOUT_CYCLES=2000, LIMIAR_CM=10, DIST_W=9.
1. Left near. medir pulse; triggers high exactly 5 clocks; echo_esq high 55 clk (5 cm); echo_dir high 300 clk (30 cm) -> pronto once; distancia_esq=5, distancia_dir=30; esq=1, dir=0, timeout=0.
2. Both near. Both echoes 80 clk (8 cm) -> dir=esq=0, distances 8/8. Then right-only near on the next medir -> dir=1, esq=0.
3. Timeout. echo_dir never rises; echo_esq 120 clk -> pronto about 2000 clk after trigger end; distancia_dir=511, distancia_esq=12, timeout=1, dir=esq=0.
4. Boundary and saturation. Echo 100 clk -> 10 cm, counts as near. Echo 109 clk -> 10 cm. Echo held for 1999 clk -> 199 cm. With DIST_W=6, a 1000-clk echo -> 63 (saturated).
5. Protocol robustness:
   - medir re-pulsed during MEDE is ignored: exactly one pronto per accepted request.
   - echo high before MEDE is ignored until it falls and rises again.
   - reset low mid-MEDE: triggers=0, outputs cleared, no pronto; state returns to 0 asynchronously.
